// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, result held in id_* until decode takes it.
// Latency: one cycle after inst_data_ok; id_stall holds id_*; redirect squashes in-flight and presented fetches.
module fetch_unit #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        redirect,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        discard, discard_nxt;
    logic [31:0] req_pc;
    logic        aligned;
    logic        cap_data, cap_exc, clr_valid, ld_req_pc;

    assign aligned   = (pc[1:0] == 2'b00);
    assign inst_addr = pc;
    assign pc_en     = !rst && (redirect || (inst_req && inst_addr_ok));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        inst_req    = 1'b0;
        cap_data    = 1'b0;
        cap_exc     = 1'b0;
        clr_valid   = 1'b0;
        ld_req_pc   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (!redirect) begin
                    if (aligned) begin
                        inst_req = 1'b1;
                        if (inst_addr_ok) begin
                            ld_req_pc = 1'b1;
                            state_nxt = WAIT;
                        end
                    end else begin
                        cap_exc   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            WAIT: begin
                // A redirect landing on the response cycle kills it directly; earlier ones arm discard.
                if (inst_data_ok) begin
                    discard_nxt = 1'b0;
                    cap_data    = !redirect && !discard;
                    state_nxt   = (redirect || discard) ? REQ : DONE;
                end else if (redirect) begin
                    discard_nxt = 1'b1;
                end
            end
            DONE: begin
                if (redirect || !id_stall) begin
                    clr_valid = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) clr_valid = 1'b1;
        if (rst) inst_req = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_exc   <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0;
            req_pc   <= 32'h0;
        end else begin
            if (ld_req_pc) req_pc <= pc;
            if (cap_data) begin
                id_valid <= 1'b1;
                id_inst  <= inst_rdata;
                id_pc    <= req_pc;
                id_exc   <= 1'b0;
            end else if (cap_exc) begin
                id_valid <= 1'b1;
                id_exc   <= 1'b1;
                id_pc    <= pc;
                id_inst  <= NOP_INST;
            end else if (clr_valid) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        redirect;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_exc;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(.NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .redirect(redirect),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_stall(id_stall),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_exc(id_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [31:0] p);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        inst_rdata = 32'h0; id_stall = 1'b0; pc = p;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starting in the IDLE cycle: accept at pc, return d on the next cycle, leave at first DONE cycle.
    task automatic fetch_one(input logic [31:0] d);
        @(negedge clk); inst_addr_ok = 1'b1;
        @(negedge clk); inst_addr_ok = 1'b0; pc = pc + 32'd4; inst_data_ok = 1'b1; inst_rdata = d;
        @(negedge clk); inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b1; inst_addr_ok = 1'b1; inst_data_ok = 1'b1;
        inst_rdata = 32'hFFFF_FFFF; id_stall = 1'b0; pc = 32'h0;
        #1;
        n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_inst_req: got %b want 0", inst_req); end
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
        @(negedge clk); #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_exc !== 1'b0) begin n_fail++; $display("FAIL reset_id_exc: got %b want 0", id_exc); end
        n_cmp++; if (id_inst !== NOP) begin n_fail++; $display("FAIL reset_id_inst: got %h want %h", id_inst, NOP); end
        n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_normal();
        do_reset(32'hBFC0_0000);
        id_stall = 1'b1; inst_addr_ok = 1'b1; #1;
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL normal_idle_pc_en: got %b want 0", pc_en); end
        @(negedge clk); #1;
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL normal_req: got req=%b addr=%h want 1/bfc00000", inst_req, inst_addr); end
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL normal_pc_en: got %b want 1", pc_en); end
        @(negedge clk); inst_addr_ok = 1'b0; pc = 32'hBFC0_0004; #1;
        n_cmp++; if (pc_en !== 1'b0 || inst_req !== 1'b0) begin n_fail++; $display("FAIL normal_wait: got pc_en=%b req=%b want 0/0", pc_en, inst_req); end
        @(negedge clk); inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; #1;
        n_cmp++; if (id_valid !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL normal_early: got valid=%b pc_en=%b want 0/0", id_valid, pc_en); end
        @(negedge clk); inst_data_ok = 1'b0; #1;
        n_cmp++;
        if (id_valid !== 1'b1 || id_inst !== 32'h2408_0001 || id_pc !== 32'hBFC0_0000 || id_exc !== 1'b0) begin
            n_fail++; $display("FAIL normal_result: got v=%b inst=%h pc=%h exc=%b want 1/24080001/bfc00000/0", id_valid, id_inst, id_pc, id_exc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d = $urandom;
        do_reset(32'h0000_0040);
        id_stall = 1'b1;
        fetch_one(d);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (id_valid !== 1'b1 || id_inst !== d || id_pc !== 32'h40 || inst_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b inst=%h pc=%h req=%b want 1/%h/40/0", i, id_valid, id_inst, id_pc, inst_req, d);
            end
            @(negedge clk);
        end
        id_stall = 1'b0; #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", id_valid); end
        @(negedge clk); #1;
        n_cmp++;
        if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h44) begin
            n_fail++; $display("FAIL stall_next_req: got v=%b req=%b addr=%h want 0/1/44", id_valid, inst_req, inst_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(32'h0000_0100);
        @(negedge clk); inst_addr_ok = 1'b1;
        @(negedge clk); inst_addr_ok = 1'b0; pc = 32'h104; redirect = 1'b1; #1;
        n_cmp++; if (pc_en !== 1'b1 || inst_req !== 1'b0) begin n_fail++; $display("FAIL redir_pulse: got pc_en=%b req=%b want 1/0", pc_en, inst_req); end
        @(negedge clk); redirect = 1'b0; pc = 32'h200; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if (inst_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait: got req=%b v=%b want 0/0", inst_req, id_valid); end
        @(negedge clk); inst_data_ok = 1'b0; #1;
        n_cmp++;
        if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h200) begin
            n_fail++; $display("FAIL redir_target: got v=%b req=%b addr=%h want 0/1/200", id_valid, inst_req, inst_addr);
        end
        @(negedge clk); #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_misalign();
        do_reset(32'h0000_0102);
        id_stall = 1'b1; inst_addr_ok = 1'b1; #1;
        n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL misalign_idle_req: got %b want 0", inst_req); end
        @(negedge clk); #1;
        n_cmp++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got req=%b pc_en=%b want 0/0", inst_req, pc_en); end
        @(negedge clk); #1;
        n_cmp++;
        if (id_valid !== 1'b1 || id_exc !== 1'b1 || id_pc !== 32'h102 || id_inst !== NOP || inst_req !== 1'b0) begin
            n_fail++; $display("FAIL misalign_result: got v=%b exc=%b pc=%h inst=%h req=%b want 1/1/102/%h/0", id_valid, id_exc, id_pc, id_inst, inst_req, NOP);
        end
        inst_addr_ok = 1'b0; id_stall = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset(32'h0000_0040);
        @(negedge clk); inst_addr_ok = 1'b1;
        @(negedge clk); inst_addr_ok = 1'b0; pc = 32'h44; redirect = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678; #1;
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL simul_pc_en: got %b want 1", pc_en); end
        @(negedge clk); redirect = 1'b0; inst_data_ok = 1'b0; pc = 32'h80; #1;
        n_cmp++;
        if (pc_en !== 1'b0 || id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h80) begin
            n_fail++; $display("FAIL simul_after: got pc_en=%b v=%b req=%b addr=%h want 0/0/1/80", pc_en, id_valid, inst_req, inst_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(32'h0000_0300);
        @(negedge clk); inst_addr_ok = 1'b1;
        @(negedge clk); inst_addr_ok = 1'b0; pc = 32'h304; rst = 1'b1; #1;
        n_cmp++; if (inst_req !== 1'b0 || pc_en !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_during: got req=%b pc_en=%b v=%b want 0/0/0", inst_req, pc_en, id_valid); end
        @(negedge clk); rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D; #1;
        n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle_req: got %b want 0", inst_req); end
        @(negedge clk); #1;
        n_cmp++;
        if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h304) begin
            n_fail++; $display("FAIL rstwait_first_req: got v=%b req=%b addr=%h want 0/1/304", id_valid, inst_req, inst_addr);
        end
        @(negedge clk); inst_data_ok = 1'b0; #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_stale: got %b want 0", id_valid); end
    endtask

    // Model: a fetch may be issued when nothing is in flight or presented; a response survives
    // only if no redirect arrives between acceptance and its return; presented words leave on
    // redirect or when decode is not stalled.
    task automatic test_random();
        bit          started = 0, outs = 0, killed = 0, pres = 0;
        logic [31:0] outs_pc = 0, p_inst = 0, p_pc = 0, tgt, r, pc_nxt;
        bit          exp_req, exp_pc_en, acc;
        do_reset(32'h0000_1000);
        for (int c = 0; c < 3000; c++) begin
            r = $urandom; tgt = r & 32'hFFFF_FFFC;
            redirect     = ($urandom_range(0, 7) == 0);
            inst_addr_ok = ($urandom_range(0, 1) == 1);
            inst_data_ok = outs ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            inst_rdata   = $urandom;
            id_stall     = ($urandom_range(0, 2) == 0);
            #1;
            exp_req   = started && !outs && !pres && !redirect && (pc[1:0] == 2'b00);
            acc       = exp_req && inst_addr_ok;
            exp_pc_en = redirect || acc;
            n_cmp++; if (inst_req !== exp_req) begin n_fail++; $display("FAIL rnd_inst_req c=%0d: got %b want %b", c, inst_req, exp_req); end
            n_cmp++; if (pc_en !== exp_pc_en) begin n_fail++; $display("FAIL rnd_pc_en c=%0d: got %b want %b", c, pc_en, exp_pc_en); end
            n_cmp++; if (id_valid !== pres) begin n_fail++; $display("FAIL rnd_id_valid c=%0d: got %b want %b", c, id_valid, pres); end
            if (exp_req) begin
                n_cmp++; if (inst_addr !== pc) begin n_fail++; $display("FAIL rnd_inst_addr c=%0d: got %h want %h", c, inst_addr, pc); end
            end
            if (pres) begin
                n_cmp++;
                if (id_inst !== p_inst || id_pc !== p_pc || id_exc !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_id_data c=%0d: got %h/%h/%b want %h/%h/0", c, id_inst, id_pc, id_exc, p_inst, p_pc);
                end
            end
            if (pres && (redirect || !id_stall)) pres = 0;
            if (outs) begin
                if (inst_data_ok) begin
                    outs = 0;
                    if (!redirect && !killed) begin pres = 1; p_inst = inst_rdata; p_pc = outs_pc; end
                    killed = 0;
                end else if (redirect) begin
                    killed = 1;
                end
            end else if (acc) begin
                outs = 1; outs_pc = pc; killed = 0;
            end
            pc_nxt  = redirect ? tgt : (acc ? pc + 32'd4 : pc);
            started = 1;
            @(negedge clk);
            pc = pc_nxt;
        end
        redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; id_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; redirect = 1'b1; inst_addr_ok = 1'b1;
        inst_data_ok = 1'b1; inst_rdata = 32'h0; id_stall = 1'b0;
        test_reset();
        test_normal();
        test_stall();
        test_redirect_inflight();
        test_misalign();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
